// File: rtl/vault_lock_ctrl.sv
// Combination lock FSM: password set/confirm, compare with wrong-bit count,
// consecutive-failure tracking and a timed lockout after MAX_TRIES misses.
module vault_lock_ctrl #(
    parameter int unsigned WIDTH          = 10,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 50_000_000,
    localparam int unsigned CW            = $clog2(WIDTH + 1),
    localparam int unsigned TW            = $clog2(LOCKOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             ENTER,
    input  logic [WIDTH-1:0] CODE,
    output logic [1:0]       STATE,
    output logic [CW-1:0]    WRONG_COUNT,
    output logic [3:0]       FAILS,
    output logic             UNLOCK,
    output logic [TW-1:0]    LOCKOUT_LEFT
);

    typedef enum logic [1:0] {
        ST_OPEN    = 2'b00,
        ST_ARM     = 2'b01,
        ST_LOCKED  = 2'b10,
        ST_LOCKOUT = 2'b11
    } state_t;

    state_t           state;
    logic             enter_q;
    logic             press;
    logic [WIDTH-1:0] password;
    logic [WIDTH-1:0] pending;
    logic [3:0]       fails_inc;

    // Number of set bits; result is 0..WIDTH and fits CW bits without wrap.
    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    assign press     = ENTER & ~enter_q;
    assign fails_inc = FAILS + 4'd1;
    assign STATE     = state;

    // enter_q resets high so a key held through reset cannot register a press.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state        <= ST_OPEN;
            enter_q      <= 1'b1;
            password     <= '0;
            pending      <= '0;
            WRONG_COUNT  <= '0;
            FAILS        <= '0;
            UNLOCK       <= 1'b0;
            LOCKOUT_LEFT <= '0;
        end else begin
            enter_q <= ENTER;
            UNLOCK  <= 1'b0;
            case (state)
                ST_OPEN: begin
                    if (press) begin
                        pending <= CODE;
                        state   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (press) begin
                        if (CODE == pending) begin
                            password    <= pending;
                            FAILS       <= '0;
                            WRONG_COUNT <= '0;
                            state       <= ST_LOCKED;
                        end else begin
                            pending <= '0;
                            state   <= ST_OPEN;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (press) begin
                        if (CODE == password) begin
                            state       <= ST_OPEN;
                            UNLOCK      <= 1'b1;
                            FAILS       <= '0;
                            WRONG_COUNT <= '0;
                        end else begin
                            WRONG_COUNT <= popcount(CODE ^ password);
                            FAILS       <= fails_inc;
                            if (fails_inc == 4'(MAX_TRIES)) begin
                                state        <= ST_LOCKOUT;
                                LOCKOUT_LEFT <= TW'(LOCKOUT_CYCLES);
                            end
                        end
                    end
                end
                ST_LOCKOUT: begin
                    // Presses are ignored here, including one on the expiry edge.
                    if (LOCKOUT_LEFT <= TW'(1)) begin
                        LOCKOUT_LEFT <= '0;
                        FAILS        <= '0;
                        state        <= ST_LOCKED;
                    end else begin
                        LOCKOUT_LEFT <= LOCKOUT_LEFT - TW'(1);
                    end
                end
                default: state <= ST_OPEN;
            endcase
        end
    end

endmodule

// File: tb/tb_vault_lock_ctrl.sv
// Directed vector table plus hand sequences for held-key reset and async reset in lockout.
module tb_vault_lock_ctrl;

    logic       clk = 1'b0;
    logic       RESET;
    logic       ENTER;
    logic [9:0] CODE;
    logic [1:0] STATE;
    logic [3:0] WRONG_COUNT;
    logic [3:0] FAILS;
    logic       UNLOCK;
    logic [3:0] LOCKOUT_LEFT;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       en;
        logic [9:0] code;
        logic [1:0] st;
        logic [3:0] wc;
        logic [3:0] f;
        logic       u;
        logic [3:0] left;
    } vec_t;

    vec_t vq[$];

    vault_lock_ctrl #(
        .WIDTH(10),
        .MAX_TRIES(3),
        .LOCKOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .RESET(RESET),
        .ENTER(ENTER),
        .CODE(CODE),
        .STATE(STATE),
        .WRONG_COUNT(WRONG_COUNT),
        .FAILS(FAILS),
        .UNLOCK(UNLOCK),
        .LOCKOUT_LEFT(LOCKOUT_LEFT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic en, input logic [9:0] code);
        ENTER = en;
        CODE  = code;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic [9:0] c, input logic [1:0] st,
                       input logic [3:0] wc, input logic [3:0] f, input logic u,
                       input logic [3:0] left);
        vq.push_back('{en, c, st, wc, f, u, left});
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [3:0] wc,
                           input logic [3:0] f, input logic u, input logic [3:0] left);
        chk({tag, " state"}, 32'(STATE), 32'(st));
        chk({tag, " wrong_count"}, 32'(WRONG_COUNT), 32'(wc));
        chk({tag, " fails"}, 32'(FAILS), 32'(f));
        chk({tag, " unlock"}, 32'(UNLOCK), 32'(u));
        chk({tag, " lockout_left"}, 32'(LOCKOUT_LEFT), 32'(left));
    endtask

    initial begin
        // en  code     st    wc f  u  left
        add(0, 10'h000, 2'd0, 0, 0, 0, 0);
        add(1, 10'h155, 2'd1, 0, 0, 0, 0);  // set password
        add(0, 10'h155, 2'd1, 0, 0, 0, 0);
        add(1, 10'h155, 2'd2, 0, 0, 0, 0);  // confirm -> locked
        add(0, 10'h155, 2'd2, 0, 0, 0, 0);
        add(1, 10'h154, 2'd2, 1, 1, 0, 0);  // one bit wrong
        add(0, 10'h155, 2'd2, 1, 1, 0, 0);  // code change without press
        add(1, 10'h155, 2'd0, 0, 0, 1, 0);  // unlock pulse
        add(0, 10'h155, 2'd0, 0, 0, 0, 0);
        add(1, 10'h3FF, 2'd1, 0, 0, 0, 0);
        add(0, 10'h3FF, 2'd1, 0, 0, 0, 0);
        add(1, 10'h000, 2'd0, 0, 0, 0, 0);  // confirm mismatch -> open
        add(0, 10'h000, 2'd0, 0, 0, 0, 0);
        add(1, 10'h0F0, 2'd1, 0, 0, 0, 0);
        add(0, 10'h0F0, 2'd1, 0, 0, 0, 0);
        add(1, 10'h0F0, 2'd2, 0, 0, 0, 0);
        add(0, 10'h0F0, 2'd2, 0, 0, 0, 0);
        add(1, 10'h3FF, 2'd2, 6, 1, 0, 0);  // 0x3FF^0x0F0 = 0x30F -> 6 bits
        add(1, 10'h155, 2'd2, 6, 1, 0, 0);  // held key, no new press
        add(0, 10'h155, 2'd2, 6, 1, 0, 0);
        add(1, 10'h0F0, 2'd0, 0, 0, 1, 0);
        add(0, 10'h0F0, 2'd0, 0, 0, 0, 0);
        add(1, 10'h001, 2'd1, 0, 0, 0, 0);
        add(0, 10'h001, 2'd1, 0, 0, 0, 0);
        add(1, 10'h001, 2'd2, 0, 0, 0, 0);
        add(0, 10'h001, 2'd2, 0, 0, 0, 0);
        add(1, 10'h000, 2'd2, 1, 1, 0, 0);
        add(0, 10'h000, 2'd2, 1, 1, 0, 0);
        add(1, 10'h000, 2'd2, 1, 2, 0, 0);
        add(0, 10'h000, 2'd2, 1, 2, 0, 0);
        add(1, 10'h000, 2'd3, 1, 3, 0, 8);  // third miss -> lockout
        add(0, 10'h000, 2'd3, 1, 3, 0, 7);
        add(1, 10'h001, 2'd3, 1, 3, 0, 6);  // correct code ignored
        add(0, 10'h001, 2'd3, 1, 3, 0, 5);
        add(1, 10'h000, 2'd3, 1, 3, 0, 4);  // wrong code ignored
        add(0, 10'h000, 2'd3, 1, 3, 0, 3);
        add(0, 10'h000, 2'd3, 1, 3, 0, 2);
        add(0, 10'h000, 2'd3, 1, 3, 0, 1);
        add(1, 10'h001, 2'd2, 1, 0, 0, 0);  // press on expiry edge ignored
        add(0, 10'h001, 2'd2, 1, 0, 0, 0);
        add(1, 10'h001, 2'd0, 0, 0, 1, 0);  // next press compares normally
        add(0, 10'h001, 2'd0, 0, 0, 0, 0);

        RESET = 1'b1;
        ENTER = 1'b0;
        CODE  = '0;
        #12;
        chk_all("reset", 2'd0, 0, 0, 1'b0, 0);
        @(posedge clk);
        #1;
        RESET = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].en, vq[i].code);
            chk_all($sformatf("v%0d", i), vq[i].st, vq[i].wc, vq[i].f, vq[i].u, vq[i].left);
        end

        // Re-enter lockout and reset asynchronously with 5 cycles left.
        step(1, 10'h001);
        step(0, 10'h001);
        step(1, 10'h001);
        step(0, 10'h001);
        for (int k = 0; k < 3; k++) begin
            step(1, 10'h000);
            step(0, 10'h000);
        end
        chk("lockout entered", 32'(STATE), 32'd3);
        for (int k = 0; k < 20 && LOCKOUT_LEFT != 4'd5; k++) step(0, 10'h000);
        chk("lockout_left reaches 5", 32'(LOCKOUT_LEFT), 32'd5);
        #2;
        RESET = 1'b1;
        #1;
        chk_all("async reset", 2'd0, 0, 0, 1'b0, 0);

        // Key held through reset release must not count as a press.
        ENTER = 1'b1;
        CODE  = 10'h2AA;
        @(posedge clk);
        #1;
        RESET = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1, 10'h2AA);
            chk($sformatf("held c%0d state", k), 32'(STATE), 32'd0);
        end
        step(0, 10'h2AA);
        chk("released state", 32'(STATE), 32'd0);
        step(1, 10'h2AA);
        chk("new press state", 32'(STATE), 32'd1);
        step(1, 10'h2AA);
        step(1, 10'h2AA);
        chk("hold after press state", 32'(STATE), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
